// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning HI/LO; holds the unit busy for a fixed
// latency per op, commits pending results at the end, and raises the D-stage stall.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic        d_is_md_i,
   output logic        busy_o,
   output logic        stall_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1) > 4 ? $clog2(MAXC + 1) : 4;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t               r_state, w_next;
   logic [CW-1:0]        r_cnt;
   logic [31:0]          r_hi_p, r_lo_p;
   logic                 r_dz;
   logic                 w_start, w_is_div, w_done, w_dz;
   logic [63:0]          w_sp, w_up;
   logic signed [31:0]   w_dv, w_sq, w_sr;
   logic [31:0]          w_uq, w_ur, w_hi_n, w_lo_n;
   assign w_is_div = md_op_i == 3'd3 || md_op_i == 3'd4;
   assign w_start  = md_op_i >= 3'd1 && md_op_i <= 3'd4 && !busy_o;
   assign w_done   = busy_o && r_cnt == CW'(1);
   assign w_dz     = rt_i == 32'd0;
   // Low 64 bits of the sign-extended product equal the signed 32x32 product.
   assign w_sp = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
   assign w_up = {32'd0, rs_i} * {32'd0, rt_i};
   // Divisor forced to 1 on divide-by-zero so the datapath never sees an undefined quotient.
   assign w_dv = w_dz ? 32'sd1 : $signed(rt_i);
   assign w_sq = $signed(rs_i) / w_dv;
   assign w_sr = $signed(rs_i) % w_dv;
   assign w_uq = rs_i / w_dv;
   assign w_ur = rs_i % w_dv;
   assign w_hi_n = md_op_i == 3'd1 ? w_sp[63:32] : md_op_i == 3'd2 ? w_up[63:32] :
                   md_op_i == 3'd3 ? w_sr : w_ur;
   assign w_lo_n = md_op_i == 3'd1 ? w_sp[31:0] : md_op_i == 3'd2 ? w_up[31:0] :
                   md_op_i == 3'd3 ? w_sq : w_uq;
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state == IDLE ? (w_start ? BUSY : IDLE) : (w_done ? IDLE : BUSY);
   end
   always_comb begin
      busy_o  = r_state == BUSY;
      stall_o = d_is_md_i && (busy_o || w_start);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_hi_p <= '0;
         r_lo_p <= '0;
         r_dz   <= 1'b0;
         hi_o   <= '0;
         lo_o   <= '0;
      end else begin
         if (w_start) begin
            r_cnt  <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_hi_p <= w_hi_n;
            r_lo_p <= w_lo_n;
            r_dz   <= w_is_div && w_dz;
         end else if (busy_o) r_cnt <= r_cnt - CW'(1);
         if (w_done && !r_dz) hi_o <= r_hi_p;
         else if (!busy_o && md_op_i == 3'd5) hi_o <= rs_i;
         if (w_done && !r_dz) lo_o <= r_lo_p;
         else if (!busy_o && md_op_i == 3'd6) lo_o <= rs_i;
      end
   end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and random checks of md_sched against a cycle-level model
// built from the op semantics (remaining-busy count, pending results, HI/LO).
module tb_md_sched;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  md_op_i;
   logic [31:0] rs_i, rt_i;
   logic        d_is_md_i;
   logic        busy_o, stall_o;
   logic [31:0] hi_o, lo_o;
   int tests = 0, fails = 0, stray = 0;
   int m_busy = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_ph = 0, m_pl = 0;
   logic m_dz = 0;

   md_sched dut (.clk(clk), .reset(reset), .md_op_i(md_op_i), .rs_i(rs_i), .rt_i(rt_i),
                 .d_is_md_i(d_is_md_i), .busy_o(busy_o), .stall_o(stall_o),
                 .hi_o(hi_o), .lo_o(lo_o));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic exp_stall;
      exp_stall = d_is_md_i && (m_busy > 0 || (md_op_i >= 3'd1 && md_op_i <= 3'd4));
      chk("busy", {31'd0, busy_o}, {31'd0, m_busy > 0});
      chk("stall", {31'd0, stall_o}, {31'd0, exp_stall});
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
   endtask

   task automatic model_edge();
      longint p;
      longint unsigned u;
      int a, b;
      int unsigned ua, ub;
      a = int'(rs_i); b = int'(rt_i); ua = rs_i; ub = rt_i;
      if (reset) begin
         m_busy = 0; m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_dz = 0;
      end else if (m_busy > 0) begin
         if (md_op_i != 3'd0 && md_op_i != 3'd7) stray++;
         m_busy--;
         if (m_busy == 0 && !m_dz) begin m_hi = m_ph; m_lo = m_pl; end
      end else begin
         case (md_op_i)
            3'd1: begin p = longint'(a) * longint'(b); m_ph = p[63:32]; m_pl = p[31:0]; m_dz = 0; m_busy = 5; end
            3'd2: begin u = longint'(ua) * longint'(ub); m_ph = u[63:32]; m_pl = u[31:0]; m_dz = 0; m_busy = 5; end
            3'd3: begin m_dz = b == 0; if (b != 0) begin m_pl = a / b; m_ph = a % b; end m_busy = 10; end
            3'd4: begin m_dz = ub == 0; if (ub != 0) begin m_pl = ua / ub; m_ph = ua % ub; end m_busy = 10; end
            3'd5: m_hi = rs_i;
            3'd6: m_lo = rs_i;
            default: ;
         endcase
      end
   endtask

   task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dmd, input logic rst = 1'b0);
      reset = rst; md_op_i = op; rs_i = a; rt_i = b; d_is_md_i = dmd;
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      reset = 1'b1; md_op_i = 0; rs_i = 0; rt_i = 0; d_is_md_i = 0;
      repeat (2) @(posedge clk);
      #1;
      step(0, 0, 0, 1, 1);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_hi", hi_o, 32'd0);
      // mult -3*5 with stall asserted throughout, plus ignored ops while busy
      step(1, 32'hFFFFFFFD, 5, 1);
      step(0, 0, 0, 1);
      step(6, 32'hAB, 0, 1);
      step(1, 2, 3, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("mult_hi", hi_o, 32'hFFFFFFFF);
      chk("mult_lo", lo_o, 32'hFFFFFFF1);
      // multu then back-to-back divu
      step(2, 32'hFFFFFFFF, 2, 0);
      repeat (5) step(0, 0, 0, 1);
      chk("multu_hi", hi_o, 32'd1);
      chk("multu_lo", lo_o, 32'hFFFFFFFE);
      step(4, 100, 7, 1);
      repeat (10) step(0, 0, 0, 1);
      chk("divu_lo", lo_o, 32'd14);
      chk("divu_hi", hi_o, 32'd2);
      step(3, 32'hFFFFFFF9, 2, 0);
      repeat (10) step(0, 0, 0, 0);
      chk("div_lo", lo_o, 32'hFFFFFFFD);
      chk("div_hi", hi_o, 32'hFFFFFFFF);
      // divide by zero leaves preloaded HI/LO alone
      step(5, 32'h11, 0, 0);
      step(6, 32'h22, 0, 1);
      step(3, 5, 0, 0);
      repeat (10) step(0, 0, 0, 1);
      chk("dz_hi", hi_o, 32'h11);
      chk("dz_lo", lo_o, 32'h22);
      // reset in the middle of a div
      step(3, 100, 3, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("mid_rst_lo", lo_o, 32'd0);
      repeat (10) step(0, 0, 0, 0);
      step(1, 6, 7, 0);
      repeat (5) step(0, 0, 0, 0);
      chk("post_rst_lo", lo_o, 32'd42);
      chk("post_rst_hi", hi_o, 32'd0);
      for (int i = 0; i < 800; i++) begin
         logic [2:0] op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         if (m_busy > 0 && $urandom_range(0, 7) != 0) op = 0;
         a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 300));
         b = $urandom_range(0, 7) == 0 ? 32'd0 :
             $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20));
         if (op == 3'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 1;
         step(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
      end
      $display("[TB] note: %0d ops were issued while busy (protocol errors, expected ignored)", stray);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
